// File: rtl/bypass_latch_gen.sv
// bypass_latch_gen: decodes the FD instruction into a 32-bit bypass word and
// carries it through the DX, XM and MW bypass registers. It also detects
// load-use hazards and keeps a saturating count of stall cycles.
// Optional feature macro: BYPASS_WR30_EN. When it is defined, bit 31 flags
// ops that may write r30 on an exception. When it is undefined, bit 31 is
// always 0.
module bypass_latch_gen (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] insn_fd,
    input  logic        valid_fd,
    input  logic        flush,
    output logic [31:0] DXB,
    output logic [31:0] XMB,
    output logic [31:0] MWB,
    output logic        stall,
    output logic [15:0] stall_count
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

`ifdef BYPASS_WR30_EN
    localparam logic WR30_EN = 1'b1;
`else
    localparam logic WR30_EN = 1'b0;
`endif

    // Saturating increment for the stall counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [4:0]  op, rd, rs, rt, alu;
    logic [4:0]  dec_a, dec_b, dec_w;
    logic        dec_lw, dec_sw, dec_wr30;
    logic [31:0] dec_word;
    logic [31:0] dx_p0, xm_p1, mw_p2;
    logic [15:0] stall_cnt_p0;
    logic [4:0]  dx_w;
    logic        alu_may_wr30;
    logic        unused_insn_bits;

    assign op  = insn_fd[31:27];
    assign rd  = insn_fd[26:22];
    assign rs  = insn_fd[21:17];
    assign rt  = insn_fd[16:12];
    assign alu = insn_fd[6:2];

    // Immediate bits outside the register fields do not affect the bypass word
    assign unused_insn_bits = ^{insn_fd[11:7], insn_fd[1:0]};

    assign alu_may_wr30 = (alu == ALU_ADD) || (alu == ALU_SUB) ||
                          (alu == ALU_MUL) || (alu == ALU_DIV);

    // Decode the FD instruction into read/write register fields and flags
    always_comb begin
        dec_a    = 5'd0;
        dec_b    = 5'd0;
        dec_w    = 5'd0;
        dec_lw   = 1'b0;
        dec_sw   = 1'b0;
        dec_wr30 = 1'b0;
        if (valid_fd) begin
            case (op)
                OP_RTYPE: begin
                    dec_a    = rs;
                    dec_b    = rt;
                    dec_w    = rd;
                    dec_wr30 = WR30_EN & alu_may_wr30;
                end
                OP_ADDI: begin
                    dec_a    = rs;
                    dec_w    = rd;
                    dec_wr30 = WR30_EN;
                end
                OP_LW: begin
                    dec_a  = rs;
                    dec_w  = rd;
                    dec_lw = 1'b1;
                end
                OP_SW: begin
                    dec_a  = rs;
                    dec_b  = rd;
                    dec_sw = 1'b1;
                end
                OP_BNE, OP_BLT: begin
                    dec_a = rd;
                    dec_b = rs;
                end
                OP_JR: begin
                    dec_a = rd;
                end
                OP_JAL: begin
                    dec_w = 5'd31;
                end
                OP_SETX: begin
                    dec_w    = 5'd30;
                    dec_wr30 = WR30_EN;
                end
                OP_BEX: begin
                    dec_a = 5'd30;
                end
                default: begin
                    dec_a = 5'd0;
                end
            endcase
        end
    end

    assign dec_word = {dec_wr30, dec_sw, dec_lw, 14'd0, dec_w, dec_b, dec_a};

    // A load in DX whose target is read by the FD instruction must wait one
    // cycle. A store's data operand is forwarded later, so it does not stall.
    // A flush squashes the FD instruction, which removes the hazard.
    assign dx_w  = dx_p0[14:10];
    assign stall = dx_p0[29] && (dx_w != 5'd0) && valid_fd && !flush &&
                   ((dec_a == dx_w) || ((dec_b == dx_w) && !dec_sw));

    // FD -> DX -> XM -> MW bypass registers; a flush or stall inserts a bubble
    always_ff @(posedge clock) begin
        if (reset) begin
            dx_p0 <= 32'd0;
            xm_p1 <= 32'd0;
            mw_p2 <= 32'd0;
        end else begin
            dx_p0 <= (flush || stall) ? 32'd0 : dec_word;
            xm_p1 <= dx_p0;
            mw_p2 <= xm_p1;
        end
    end

    // Count stall cycles; the count holds at all-ones
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_p0 <= 16'd0;
        end else if (stall) begin
            stall_cnt_p0 <= sat_inc16(stall_cnt_p0);
        end
    end

    assign DXB         = dx_p0;
    assign XMB         = xm_p1;
    assign MWB         = mw_p2;
    assign stall_count = stall_cnt_p0;

endmodule

// File: doc/bypass_latch_gen.md
# bypass_latch_gen

Producer side of the pipeline forwarding path. Decodes the fetched instruction into the 32-bit bypass latch word and carries it through the DX, XM and MW bypass registers, in lock-step with the datapath pipeline latches. It drives `DXB`, `XMB` and `MWB` to the forwarding unit and detects load-use hazards, asserting `stall`. It also counts stall cycles for performance monitoring.

## Interface
No parameters.

- `clock`  in  1  pipeline clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock and synchronous active-high reset are fixed for this block.
- `insn_fd`  in  32  instruction currently in the FD latch.
- `valid_fd`  in  1  `insn_fd` holds a real instruction (0 means bubble).
- `flush`  in  1  taken branch/jump resolved in X; squash the FD instruction.
- `DXB`  out  32  bypass word in DX.
- `XMB`  out  32  bypass word in XM.
- `MWB`  out  32  bypass word in MW.
- `stall`  out  1  load-use hazard; hold PC/FD and insert a bubble into DX.
- `stall_count`  out  16  saturating count of stall cycles.

## Operation
Bypass word format:
- `[4:0]` readregA.
- `[9:5]` readregB.
- `[14:10]` regtowrite.
- `[28:15]` always 0.
- `[29]` lw.
- `[30]` sw.
- `[31]` writeto30.

Decode of `insn_fd` uses opcode `[31:27]`, rd `[26:22]`, rs `[21:17]`, rt `[16:12]`, ALU op `[6:2]`:
- R-type `00000`: A=rs, B=rt, W=rd.
- addi `00101`: A=rs, B=0, W=rd.
- lw `01000`: A=rs, B=0, W=rd, bit 29=1.
- sw `00111`: A=rs, B=rd, W=0, bit 30=1.
- bne `00010` and blt `00110`: A=rd, B=rs, W=0.
- jr `00100`: A=rd, B=0, W=0.
- jal `00011`: W=31, A=B=0.
- setx `10101`: W=30, A=B=0.
- bex `10110`: A=30, B=0, W=0.
- j `00001`, and all other opcodes: word = 0.
- `valid_fd`=0 gives word = 0.
- Any field equal to 0 stays 0. Register 0 is never a hazard.

Hazard detection (combinational):
- `stall` = `DXB[29]` & (`DXB[14:10]`≠0) & `valid_fd` & !`flush` & (decA==`DXB[14:10]` | (decB==`DXB[14:10]` & !dec_sw)).
- A store whose data register is the load target does not stall; the MW→DMEM data path covers it.

Register update each clock edge:
- DX ← 0 if `flush` or `stall`, else the decoded word.
- XM ← DX.
- MW ← XM.
- No enable input: the pipeline always advances below FD.

Stall counter:
- `stall_count` increments when `stall`=1.
- Saturates at 16'hFFFF.
- Clears only on reset.

## Timing
- Reset: `DXB`=`XMB`=`MWB`=0 and `stall_count`=0 on the first edge with `reset`=1. `stall` is then 0, since it is derived from `DXB`.
- Decode latency: the word for `insn_fd` appears on `DXB` 1 cycle later, `XMB` 2 cycles later, `MWB` 3 cycles later.
- `stall` is valid in the same cycle the hazard exists and depends only on the current inputs and `DXB`.
- After one stall cycle the lw has moved to XM, so `stall` drops. A load-use hazard costs exactly 1 bubble.
- `flush` and `stall` together: `flush` wins. DX gets 0 and `stall` is forced to 0, so the counter does not increment.
- Reset mid-pipeline: all three words clear in the same edge. In-flight entries are discarded.

## Configuration
- `BYPASS_WR30_EN` defined:
  - bit 31 = 1 for R-type ALU op add `00000`, sub `00001`, mul `00110`, div `00111`, and for addi.
  - bit 31 = 1 for setx.
  - These are the ops that may write r30 on an exception.
- Undefined: bit 31 is constant 0. All other behaviour is identical.

## Test plan
- Reset, then 3 idle cycles: `DXB`/`XMB`/`MWB`=0, `stall`=0, `stall_count`=0.
- addi r3,r1,5 (valid, no hazard): `DXB`=32'h0000_0C01 after 1 cycle (W=3, A=1). It reaches `XMB` and `MWB` on the next two edges. With `BYPASS_WR30_EN` defined, bit 31 is also set.
- lw r4,0(r2) followed by add r5,r4,r1:
  - `stall`=1 for exactly one cycle.
  - `DXB`=0 for the bubble.
  - The add's word reaches `DXB` one cycle later.
  - `stall_count`=1.
- lw r4 followed by sw r4,0(r6) (r4 as data): `stall`=0. lw followed by sw r6,0(r4) (r4 as base): `stall`=1.
- lw r4 followed by add r5,r4,r1 with `flush`=1 in the same cycle: `stall`=0, `DXB`←0, `stall_count` unchanged.
- Counter saturation: force 65,540 hazard cycles; `stall_count` holds at 16'hFFFF. Reset mid-sequence clears all outputs to 0 at the next edge.
